// File: rtl/btn_event_decoder.sv
// Button event decoder: turns a debounced level into single/double/long/repeat strobes.
// Optional auto-repeat while a long press is held is enabled by defining BTN_EVENT_REPEAT_EN.
module btn_event_decoder #(
   parameter int N            = 16,
   parameter int LONG_TICKS   = 25000,
   parameter int GAP_TICKS    = 15000,
   parameter int REPEAT_TICKS = 10000
) (
   input  logic clk,
   input  logic reset,
   input  logic db_in,
   output logic single_pulse,
   output logic double_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT_GAP  = 3'd2,
      PRESS2    = 3'd3,
      LONG_HELD = 3'd4
   } state_t;

   localparam logic [N-1:0] LONG_LAST = N'(LONG_TICKS - 1);
   localparam logic [N-1:0] GAP_LAST  = N'(GAP_TICKS - 1);

   state_t         state_q, state_d;
   logic [N-1:0]   cnt_q, cnt_d;
   logic           db_q;
   logic           single_q, single_d;
   logic           double_q, double_d;
   logic           long_q, long_d;
   logic           rise, fall;

   assign rise = db_in & ~db_q;
   assign fall = ~db_in & db_q;

`ifdef BTN_EVENT_REPEAT_EN
   localparam logic [N-1:0] REPEAT_LAST = N'(REPEAT_TICKS - 1);
   logic repeat_q, repeat_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         db_q     <= 1'b0;
         single_q <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         db_q     <= db_in;
         single_q <= single_d;
         double_q <= double_d;
         long_q   <= long_d;
      end
   end

   // Edges are tested before threshold matches so a release/press wins a same-cycle tie.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      single_d = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
      repeat_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (rise) state_d = PRESS1;
         end
         PRESS1: begin
            if (fall) begin
               state_d = WAIT_GAP;
            end else if (db_in && cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_GAP: begin
            if (rise) begin
               state_d  = PRESS2;
               double_d = 1'b1;
            end else if (!db_in && cnt_q == GAP_LAST) begin
               state_d  = IDLE;
               single_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESS2: begin
            if (fall) state_d = IDLE;
         end
         LONG_HELD: begin
            if (fall) begin
               state_d = IDLE;
`ifdef BTN_EVENT_REPEAT_EN
            end else if (db_in && cnt_q == REPEAT_LAST) begin
               repeat_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

`ifdef BTN_EVENT_REPEAT_EN
   always_ff @(posedge clk) begin
      if (reset) repeat_q <= 1'b0;
      else       repeat_q <= repeat_d;
   end
   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign single_pulse = single_q;
   assign double_pulse = double_q;
   assign long_pulse   = long_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: timestamp-based reference model compared every cycle,
// directed scenarios pinned to hand-computed strobe cycles, then randomized press/release runs.
module tb_btn_event_decoder;

   localparam int LT = 20;
   localparam int GT = 10;
   localparam int RT = 5;
`ifdef BTN_EVENT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic db_in = 1'b0;
   logic single_pulse, double_pulse, long_pulse, repeat_pulse, busy;

   btn_event_decoder #(.N(16), .LONG_TICKS(LT), .GAP_TICKS(GT), .REPEAT_TICKS(RT)) dut (
      .clk(clk), .reset(reset), .db_in(db_in),
      .single_pulse(single_pulse), .double_pulse(double_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phases with the edge index at which each phase was entered.
   localparam int P_IDLE = 0, P_DOWN1 = 1, P_GAP = 2, P_DOWN2 = 3, P_LONG = 4;
   int  m_phase = P_IDLE;
   int  m_t0 = 0;
   bit  m_prev = 1'b0;
   bit  e_s, e_d, e_l, e_r;
   int  edge_n = 0;

   // Per-scenario records, indexed by cycle relative to the scenario start.
   bit  recording = 1'b0;
   int  base_edge = 0;
   int  s_q[$], d_q[$], l_q[$], r_q[$];
   int  busy_at[64];

   always @(posedge clk) begin
      int  k;
      bit  rise, fall;
      k = edge_n;
      edge_n++;
      e_s = 0; e_d = 0; e_l = 0; e_r = 0;
      if (reset) begin
         m_phase = P_IDLE;
         m_prev  = 1'b0;
      end else begin
         rise = db_in && !m_prev;
         fall = !db_in && m_prev;
         case (m_phase)
            P_IDLE:  if (rise) begin m_phase = P_DOWN1; m_t0 = k; end
            P_DOWN1: if (fall) begin m_phase = P_GAP; m_t0 = k; end
                     else if (db_in && k - m_t0 == LT) begin m_phase = P_LONG; m_t0 = k; e_l = 1; end
            P_GAP:   if (rise) begin m_phase = P_DOWN2; e_d = 1; end
                     else if (!db_in && k - m_t0 == GT) begin m_phase = P_IDLE; e_s = 1; end
            P_DOWN2: if (fall) m_phase = P_IDLE;
            P_LONG:  if (fall) m_phase = P_IDLE;
                     else if (REP_EN && db_in && k - m_t0 == RT) begin m_t0 = k; e_r = 1; end
            default: m_phase = P_IDLE;
         endcase
         m_prev = db_in;
      end
      #1;
      chk("single_pulse", 32'(single_pulse), 32'(e_s));
      chk("double_pulse", 32'(double_pulse), 32'(e_d));
      chk("long_pulse",   32'(long_pulse),   32'(e_l));
      chk("repeat_pulse", 32'(repeat_pulse), 32'(e_r));
      chk("busy",         32'(busy),         32'(m_phase != P_IDLE));
      if (recording && (k - base_edge + 1) < 64) begin
         if (single_pulse === 1'b1) s_q.push_back(k - base_edge + 1);
         if (double_pulse === 1'b1) d_q.push_back(k - base_edge + 1);
         if (long_pulse   === 1'b1) l_q.push_back(k - base_edge + 1);
         if (repeat_pulse === 1'b1) r_q.push_back(k - base_edge + 1);
         busy_at[k - base_edge + 1] = (busy === 1'b1) ? 1 : 0;
      end
   end

   function automatic int first_of(input int q[$]);
      return (q.size() == 0) ? -1 : q[0];
   endfunction

   // Bit i of lv/rv is the db_in/reset level sampled at scenario cycle i.
   task automatic play(input int len, input logic [63:0] lv, input logic [63:0] rv);
      s_q.delete(); d_q.delete(); l_q.delete(); r_q.delete();
      for (int c = 0; c < 64; c++) busy_at[c] = -1;
      @(negedge clk);
      base_edge = edge_n;
      recording = 1'b1;
      for (int i = 0; i < len; i++) begin
         db_in = lv[i];
         reset = rv[i];
         @(negedge clk);
      end
      recording = 1'b0;
      db_in = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      bit lvl;
      int len;
      int picks[8];
      repeat (3) @(negedge clk);
      chk("rst_single", 32'(single_pulse), 32'd0);
      chk("rst_double", 32'(double_pulse), 32'd0);
      chk("rst_long",   32'(long_pulse),   32'd0);
      chk("rst_repeat", 32'(repeat_pulse), 32'd0);
      chk("rst_busy",   32'(busy),         32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single click
      play(40, 64'h1F, 64'h0);
      chk("sc_single_n",   s_q.size(), 1);
      chk("sc_single_cyc", first_of(s_q), 16);
      chk("sc_double_n",   d_q.size(), 0);
      chk("sc_busy15",     busy_at[15], 1);
      chk("sc_busy16",     busy_at[16], 0);

      // Double click
      play(40, 64'h7C1F, 64'h0);
      chk("dc_double_n",   d_q.size(), 1);
      chk("dc_double_cyc", first_of(d_q), 11);
      chk("dc_single_n",   s_q.size(), 0);
      chk("dc_busy15",     busy_at[15], 1);
      chk("dc_busy16",     busy_at[16], 0);

      // Long press held 0-29
      play(40, 64'h3FFF_FFFF, 64'h0);
      chk("lp_long_n",   l_q.size(), 1);
      chk("lp_long_cyc", first_of(l_q), 21);
      chk("lp_single_n", s_q.size(), 0);
      if (REP_EN) begin
         chk("lp_repeat_n",   r_q.size(), 1);
         chk("lp_repeat_cyc", first_of(r_q), 26);
      end else begin
         chk("lp_repeat_n",   r_q.size(), 0);
      end
      chk("lp_busy30", busy_at[30], 1);
      chk("lp_busy31", busy_at[31], 0);

      // Release exactly at the long threshold
      play(40, 64'hF_FFFF, 64'h0);
      chk("bd_long_n",     l_q.size(), 0);
      chk("bd_single_cyc", first_of(s_q), 31);
      chk("bd_single_n",   s_q.size(), 1);

      // Reset in the middle of the gap
      play(40, 64'h1F, 64'h400);
      chk("rg_strobes", s_q.size() + d_q.size() + l_q.size() + r_q.size(), 0);
      chk("rg_busy10",  busy_at[10], 1);
      chk("rg_busy11",  busy_at[11], 0);

      // Button held high through reset: rise right after reset
      play(40, 64'h3FF, 64'h8);
      chk("rh_busy4",       busy_at[4], 0);
      chk("rh_busy5",       busy_at[5], 1);
      chk("rh_single_cyc",  first_of(s_q), 21);

      // Randomized press/release runs around every threshold
      picks = '{LT - 1, LT, LT + 1, GT - 1, GT, GT + 1, RT, 1};
      lvl = 1'b0;
      for (int s = 0; s < 90; s++) begin
         lvl = ~lvl;
         if ($urandom_range(0, 1) == 0) len = picks[$urandom_range(0, 7)];
         else len = $urandom_range(1, 35);
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            db_in = lvl;
            reset = ($urandom_range(0, 150) == 0);
         end
      end
      @(negedge clk);
      db_in = 1'b0;
      reset = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
